game_sequencer: RTL

- Central game-flow controller for the Darth Invaders top level.
- Takes synchronized button levels, a per-frame tick from the VGA timing block, and hit and clear events from the sprite/collision logic.
- Sequences the game states, moves the player ship, and arbitrates the single player shot.
- Drives the lives, score and wave registers consumed by the renderer.

---
 rtl/game_pkg.sv | 20 ++
 rtl/shot_unit.sv | 70 +++++++
 rtl/game_sequencer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared game-flow encodings and screen geometry for the Darth Invaders top level.
// Widths here are also consumed by the renderer and collision blocks.
package game_pkg;

   localparam int H_ACTIVE = 640;
   localparam int SHOT_Y0  = 440;

   localparam int X_W     = 10;
   localparam int Y_W     = 9;
   localparam int LIVES_W = 3;
   localparam int WAVE_W  = 4;

   typedef enum logic [1:0] {
      ST_ATTRACT = 2'd0,
      ST_PLAY    = 2'd1,
      ST_DYING   = 2'd2,
      ST_OVER    = 2'd3
   } state_t;

endpackage

// File: rtl/shot_unit.sv
// Player shot register plus fire-button edge latch; optional AUTOFIRE_EN refires while btn_u is held.
// Latency: one cycle, registered outputs; no backpressure (all inputs are level or single-cycle pulses).
module shot_unit
   import game_pkg::*;
#(
   parameter int PLAYER_W   = 32,
   parameter int SHOT_SPEED = 8
) (
   input  logic           master_clk,
   input  logic           BTN_Reset,
   input  logic           frame_tick,
   input  logic           btn_u,
   input  logic           play,
   input  logic           clr,
   input  logic [X_W-1:0] player_x,
   output logic           fire_req,
   output logic           shot_active,
   output logic [X_W-1:0] shot_x,
   output logic [Y_W-1:0] shot_y
);

   localparam logic [Y_W-1:0] SPEED  = Y_W'(SHOT_SPEED);
   localparam logic [Y_W-1:0] LAUNCH = Y_W'(SHOT_Y0);
   localparam logic [X_W-1:0] HALF_W = X_W'(PLAYER_W / 2);

   logic btn_u_q;
   logic rise;
   logic fire_eff;

   assign rise = btn_u & ~btn_u_q;

`ifdef AUTOFIRE_EN
   assign fire_eff = fire_req | (play & btn_u);
`else
   assign fire_eff = fire_req;
`endif

   always_ff @(posedge master_clk or posedge BTN_Reset) begin
      if (BTN_Reset) begin
         btn_u_q     <= 1'b0;
         fire_req    <= 1'b0;
         shot_active <= 1'b0;
         shot_x      <= '0;
         shot_y      <= LAUNCH;
      end else begin
         btn_u_q <= btn_u;
         // A tick consumes the pending request; an edge arriving on that same cycle waits for the next tick.
         if (frame_tick)
            fire_req <= rise;
         else if (rise)
            fire_req <= 1'b1;

         if (clr) begin
            shot_active <= 1'b0;
         end else if (frame_tick && play) begin
            if (shot_active) begin
               if (shot_y < SPEED)
                  shot_active <= 1'b0;
               else
                  shot_y <= shot_y - SPEED;
            end else if (fire_eff) begin
               shot_active <= 1'b1;
               shot_x      <= player_x + HALF_W;
               shot_y      <= LAUNCH;
            end
         end
      end
   end

endmodule

// File: rtl/game_sequencer.sv
// Game-flow controller: state machine, ship movement, lives/score/wave; shot handled by shot_unit (AUTOFIRE_EN option).
// Latency: all outputs registered, frame_tick updates visible next cycle; no backpressure.
module game_sequencer
   import game_pkg::*;
#(
   parameter int PLAYER_W     = 32,
   parameter int PLAYER_STEP  = 4,
   parameter int SHOT_SPEED   = 8,
   parameter int LIVES_INIT   = 3,
   parameter int DEATH_FRAMES = 60,
   parameter int SCORE_W      = 16
) (
   input  logic               master_clk,
   input  logic               BTN_Reset,
   input  logic               frame_tick,
   input  logic               btn_l,
   input  logic               btn_r,
   input  logic               btn_u,
   input  logic               alien_hit,
   input  logic               player_hit,
   input  logic               aliens_cleared,
   output logic [1:0]         state,
   output logic [X_W-1:0]     player_x,
   output logic               shot_active,
   output logic [X_W-1:0]     shot_x,
   output logic [Y_W-1:0]     shot_y,
   output logic [LIVES_W-1:0] lives,
   output logic [SCORE_W-1:0] score,
   output logic [WAVE_W-1:0]  wave,
   output logic               wave_start
);

   localparam int CNT_W = $clog2(DEATH_FRAMES + 1);

   localparam logic [X_W-1:0]     X_MAX  = X_W'(H_ACTIVE - PLAYER_W);
   localparam logic [X_W-1:0]     X_CTR  = X_W'((H_ACTIVE - PLAYER_W) / 2);
   localparam logic [X_W-1:0]     STEP   = X_W'(PLAYER_STEP);
   localparam logic [X_W-1:0]     R_LIM  = X_W'(H_ACTIVE - PLAYER_W - PLAYER_STEP);
   localparam logic [LIVES_W-1:0] L_INIT = LIVES_W'(LIVES_INIT);
   localparam logic [CNT_W-1:0]   D_INIT = CNT_W'(DEATH_FRAMES);

   state_t           st;
   logic [CNT_W-1:0] death_cnt;
   logic             fire_req;
   logic             in_play;

   assign state   = st;
   assign in_play = (st == ST_PLAY);

   shot_unit #(
      .PLAYER_W   (PLAYER_W),
      .SHOT_SPEED (SHOT_SPEED)
   ) u_shot (
      .master_clk  (master_clk),
      .BTN_Reset   (BTN_Reset),
      .frame_tick  (frame_tick),
      .btn_u       (btn_u),
      .play        (in_play),
      .clr         (in_play & (alien_hit | player_hit | aliens_cleared)),
      .player_x    (player_x),
      .fire_req    (fire_req),
      .shot_active (shot_active),
      .shot_x      (shot_x),
      .shot_y      (shot_y)
   );

   always_ff @(posedge master_clk or posedge BTN_Reset) begin
      if (BTN_Reset) begin
         st         <= ST_ATTRACT;
         player_x   <= X_CTR;
         lives      <= L_INIT;
         score      <= '0;
         wave       <= '0;
         wave_start <= 1'b0;
         death_cnt  <= '0;
      end else begin
         wave_start <= 1'b0;
         case (st)
            ST_ATTRACT: begin
               if (frame_tick && fire_req) begin
                  st         <= ST_PLAY;
                  lives      <= L_INIT;
                  score      <= '0;
                  wave       <= '0;
                  wave_start <= 1'b1;
               end
            end
            ST_PLAY: begin
               if (frame_tick && (btn_l ^ btn_r)) begin
                  if (btn_l)
                     player_x <= (player_x < STEP) ? '0 : player_x - STEP;
                  else
                     player_x <= (player_x > R_LIM) ? X_MAX : player_x + STEP;
               end
               if (alien_hit && (score != '1))
                  score <= score + SCORE_W'(1);
               if (aliens_cleared) begin
                  if (wave != '1)
                     wave <= wave + WAVE_W'(1);
                  wave_start <= 1'b1;
               end
               // player_hit decides the next state even when other events coincide
               if (player_hit) begin
                  lives <= lives - LIVES_W'(1);
                  if (lives == LIVES_W'(1)) begin
                     st <= ST_OVER;
                  end else begin
                     st        <= ST_DYING;
                     death_cnt <= D_INIT;
                  end
               end
            end
            ST_DYING: begin
               if (frame_tick) begin
                  if (death_cnt <= CNT_W'(1)) begin
                     death_cnt <= '0;
                     player_x  <= X_CTR;
                     st        <= ST_PLAY;
                  end else begin
                     death_cnt <= death_cnt - CNT_W'(1);
                  end
               end
            end
            ST_OVER: begin
               if (frame_tick && fire_req)
                  st <= ST_ATTRACT;
            end
            default: st <= ST_ATTRACT;
         endcase
      end
   end

endmodule
